uart_imem_loader: RTL

Boot-time program loader that sits directly upstream of the CPU core inside cpu_uart_top. It receives a program image over a UART RX line and assembles little-endian bytes into 32-bit instruction words. It writes the words sequentially into instruction memory and holds the CPU in reset until NUM_WORDS words are stored. After that it releases the CPU and ignores further serial traffic.

---
 rtl/uart_imem_loader_pkg.sv | 23 ++
 rtl/uart_imem_loader_rx_byte.sv | 119 +++++++++++
 rtl/uart_imem_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared constants for the UART boot loader: 8N1 frame geometry, FSM encodings
// and the default image size, which follows CELL_NUMBERS when that is defined.
`ifndef CELL_NUMBERS
`define CELL_NUMBERS 64
`endif

package uart_imem_loader_pkg;

    localparam int DATA_BITS = 8;

    localparam int DEFAULT_NUM_WORDS = `CELL_NUMBERS;

    typedef logic [DATA_BITS-1:0] rx_byte_t;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic LD_LOAD = 1'b0;
    localparam logic LD_DONE = 1'b1;

endpackage

// File: rtl/uart_imem_loader_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte strobe
// and a one-cycle pulse whenever a stop bit is sampled low.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic           sync1_q, sync2_q;
    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    rx_byte_t       shift_q, shift_d;
    logic           byte_valid_q, byte_valid_d;
    logic           ferr_q, ferr_d;
    logic           stop_err_q, stop_err_d;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        ferr_d       = 1'b0;
        stop_err_d   = stop_err_q;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d   = RX_START;
                    clk_cnt_d = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                // After a bad stop bit, stay here until the line idles high.
                if (stop_err_q) begin
                    if (sync2_q) begin
                        stop_err_d = 1'b0;
                        state_d    = RX_IDLE;
                    end
                end else if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        stop_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            ferr_q       <= ferr_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign rx_byte         = shift_q;
    assign byte_valid      = byte_valid_q;
    assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs little-endian UART bytes into 32-bit words, writes them to
// IMEM in order and holds the CPU in reset until NUM_WORDS words are stored.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_WORDS    = DEFAULT_NUM_WORDS,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              cpu_hold,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              frame_err_pulse;

    logic              state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       assembled;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              load_done_q, load_done_d;
    logic              frame_err_q, frame_err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk            (clk),
        .rst            (rst),
        .uart_rx        (uart_rx),
        .rx_byte        (rx_byte),
        .byte_valid     (byte_valid),
        .frame_err_pulse(frame_err_pulse)
    );

    always_comb begin
        assembled = word_q;
        assembled[{byte_cnt_q, 3'b000} +: DATA_BITS] = rx_byte;
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = load_done_q | (state_q == LD_DONE);
        frame_err_d  = frame_err_q | frame_err_pulse;
        if (state_q == LD_LOAD && byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = assembled;
            if (byte_cnt_q == 2'd3) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = word_cnt_q;
                imem_wdata_d = assembled;
                word_d       = '0;
                // The counter stops at the last address so imem_addr never wraps.
                if (word_cnt_q == LAST_ADDR) begin
                    state_d = LD_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LD_LOAD;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            load_done_q  <= load_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign load_done  = load_done_q;
    assign cpu_hold   = ~load_done_q;
    assign frame_err  = frame_err_q;

endmodule
